// File: rtl/rgb2hsv_pkg.sv
`default_nettype none
// ============================================================================
// rgb2hsv_pkg : sizing helpers and max-channel encoding for rgb2hsv_pipe
// Revision    : 1.0
// ============================================================================
package rgb2hsv_pkg;

   localparam logic [1:0] IDX_R = 2'd0;
   localparam logic [1:0] IDX_G = 2'd1;
   localparam logic [1:0] IDX_B = 2'd2;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

   function automatic int calc_hue_w(input int hue_mode, input int data_w);
      return (hue_mode == 1) ? 9 : data_w;
   endfunction

   function automatic int calc_latency(input int hue_mode, input int data_w);
      int hue_w;
      hue_w = calc_hue_w(hue_mode, data_w);
      return ((hue_w > data_w) ? hue_w : data_w) + 3;
   endfunction

endpackage
`default_nettype wire

// File: rtl/div_pipe.sv
`default_nettype none
// ============================================================================
// div_pipe : pipelined restoring divider, one quotient bit per stage, MSB first
// Revision : 1.0
// ============================================================================
module div_pipe #(
   parameter int NUM_W = 16,
   parameter int DEN_W = 8,
   parameter int Q_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ce,
   input  logic [NUM_W-1:0] num,
   input  logic [DEN_W-1:0] den,
   output logic [Q_W-1:0]   q
);

   localparam int CW = (NUM_W > DEN_W + Q_W) ? NUM_W : DEN_W + Q_W;

   logic [CW-1:0]    r_rem [Q_W-1];
   logic [DEN_W-1:0] r_den [Q_W-1];
   logic [Q_W-1:0]   r_q   [Q_W];

   generate
      for (genvar i = 0; i < Q_W; i++) begin : g_stage
         localparam int K = Q_W - 1 - i;
         logic [CW-1:0]    w_rem;
         logic [CW-1:0]    w_sub;
         logic [DEN_W-1:0] w_den;
         logic [Q_W-1:0]   w_q;
         logic             w_ge;

         if (i == 0) begin : g_head
            // a zero divisor becomes 1 so the stage math stays defined; the top masks it
            assign w_rem = CW'(num);
            assign w_den = (den == '0) ? DEN_W'(1) : den;
            assign w_q   = '0;
         end else begin : g_body
            assign w_rem = r_rem[i-1];
            assign w_den = r_den[i-1];
            assign w_q   = r_q[i-1];
         end

         assign w_sub = CW'(w_den) << K;
         assign w_ge  = (w_rem >= w_sub);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_q[i] <= '0;
            end else if (ce) begin
               r_q[i] <= w_q | (Q_W'(w_ge) << K);
            end
         end

         if (i < Q_W - 1) begin : g_carry
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  r_rem[i] <= '0;
                  r_den[i] <= '0;
               end else if (ce) begin
                  r_rem[i] <= w_ge ? (w_rem - w_sub) : w_rem;
                  r_den[i] <= w_den;
               end
            end
         end
      end
   endgenerate

   assign q = r_q[Q_W-1];

endmodule
`default_nettype wire

// File: rtl/rgb2hsv_pipe.sv
`default_nettype none
// ============================================================================
// rgb2hsv_pipe : fixed-latency pipelined RGB to HSV converter with sideband
// Revision     : 1.0
// ============================================================================
module rgb2hsv_pipe
   import rgb2hsv_pkg::*;
#(
   parameter int  DATA_W   = 8,
   parameter int  HUE_MODE = 0,
   parameter int  SYNC_W   = 3,
   localparam int HUE_W    = calc_hue_w(HUE_MODE, DATA_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ce,
   input  logic              in_valid,
   input  logic [SYNC_W-1:0] sync_in,
   input  logic [DATA_W-1:0] red,
   input  logic [DATA_W-1:0] green,
   input  logic [DATA_W-1:0] blue,
   output logic              out_valid,
   output logic [SYNC_W-1:0] sync_out,
   output logic [HUE_W-1:0]  h,
   output logic [DATA_W-1:0] s,
   output logic [DATA_W-1:0] v
);

   localparam int QW      = (HUE_W > DATA_W) ? HUE_W : DATA_W;
   localparam int LATENCY = calc_latency(HUE_MODE, DATA_W);
   localparam int HSCALE  = (HUE_MODE == 1) ? 360 : (1 << DATA_W);
   localparam int FS      = (1 << DATA_W) - 1;
   localparam int SW      = DATA_W + 4;
   localparam int HNUM_W  = SW + clog2(HSCALE + 1);
   localparam int SNUM_W  = 2 * DATA_W;

   logic [DATA_W-1:0] w_mx, w_mn;
   logic [1:0]        w_idx;
   logic [DATA_W-1:0] r1_r, r1_g, r1_b, r1_mx, r1_delta;
   logic [1:0]        r1_idx;

   always_comb begin
      w_idx = IDX_R;
      w_mx  = red;
      if (red >= green && red >= blue) begin
         w_idx = IDX_R;
         w_mx  = red;
      end else if (green >= blue) begin
         w_idx = IDX_G;
         w_mx  = green;
      end else begin
         w_idx = IDX_B;
         w_mx  = blue;
      end
      w_mn = red;
      if (green < w_mn) w_mn = green;
      if (blue < w_mn)  w_mn = blue;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_r <= '0; r1_g <= '0; r1_b <= '0;
         r1_mx <= '0; r1_delta <= '0; r1_idx <= IDX_R;
      end else if (ce) begin
         r1_r <= red; r1_g <= green; r1_b <= blue;
         r1_mx <= w_mx; r1_delta <= w_mx - w_mn; r1_idx <= w_idx;
      end
   end

   logic signed [DATA_W:0] w_num;
   logic [SW-1:0]          w_d, w_base, w_six_d;
   logic signed [SW-1:0]   w_sum, w_hn;

   always_comb begin
      w_d     = SW'(r1_delta);
      w_six_d = (w_d << 2) + (w_d << 1);
      w_num   = $signed({1'b0, r1_g}) - $signed({1'b0, r1_b});
      w_base  = '0;
      case (r1_idx)
         IDX_G: begin
            w_num  = $signed({1'b0, r1_b}) - $signed({1'b0, r1_r});
            w_base = w_d << 1;
         end
         IDX_B: begin
            w_num  = $signed({1'b0, r1_r}) - $signed({1'b0, r1_g});
            w_base = w_d << 2;
         end
         default: begin
            w_num  = $signed({1'b0, r1_g}) - $signed({1'b0, r1_b});
            w_base = '0;
         end
      endcase
      // only the red sector can go negative; one wrap of 6*delta lands it in range
      w_sum = $signed(w_base) + $signed({{(SW-DATA_W-1){w_num[DATA_W]}}, w_num});
      w_hn  = w_sum[SW-1] ? (w_sum + $signed(w_six_d)) : w_sum;
   end

   logic [HNUM_W-1:0] r2_hnum;
   logic [SW-1:0]     r2_hden;
   logic [SNUM_W-1:0] r2_snum;
   logic [DATA_W-1:0] r2_sden, r2_mx;
   logic              r2_hzero, r2_szero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r2_hnum <= '0; r2_hden <= '0; r2_snum <= '0; r2_sden <= '0;
         r2_mx <= '0; r2_hzero <= 1'b0; r2_szero <= 1'b0;
      end else if (ce) begin
         r2_hnum  <= HNUM_W'($unsigned(w_hn)) * HNUM_W'(HSCALE);
         r2_hden  <= w_six_d;
         r2_snum  <= SNUM_W'(r1_delta) * SNUM_W'(FS);
         r2_sden  <= r1_mx;
         r2_mx    <= r1_mx;
         r2_hzero <= (r1_delta == '0);
         r2_szero <= (r1_mx == '0);
      end
   end

   logic [QW-1:0] w_hq, w_sq;

   div_pipe #(.NUM_W(HNUM_W), .DEN_W(SW), .Q_W(QW)) u_hdiv (
      .clk(clk), .rst_n(rst_n), .ce(ce), .num(r2_hnum), .den(r2_hden), .q(w_hq)
   );

   div_pipe #(.NUM_W(SNUM_W), .DEN_W(DATA_W), .Q_W(QW)) u_sdiv (
      .clk(clk), .rst_n(rst_n), .ce(ce), .num(r2_snum), .den(r2_sden), .q(w_sq)
   );

   logic [HUE_W-1:0]  w_h_val;
   logic [DATA_W-1:0] w_s_val;

   // quotient bits above the output width are always zero; fold them in as a saturate
   generate
      if (QW > HUE_W) begin : g_h_sat
         assign w_h_val = (|w_hq[QW-1:HUE_W]) ? '1 : w_hq[HUE_W-1:0];
      end else begin : g_h_full
         assign w_h_val = w_hq;
      end
      if (QW > DATA_W) begin : g_s_sat
         assign w_s_val = (|w_sq[QW-1:DATA_W]) ? '1 : w_sq[DATA_W-1:0];
      end else begin : g_s_full
         assign w_s_val = w_sq;
      end
   endgenerate

   logic [DATA_W-1:0]  r_mx_d [QW];
   logic [QW-1:0]      r_hz_d, r_sz_d;
   logic [LATENCY-1:0] r_vld;
   logic [SYNC_W-1:0]  r_sync [LATENCY];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < QW; i++) r_mx_d[i] <= '0;
         for (int i = 0; i < LATENCY; i++) r_sync[i] <= '0;
         r_hz_d <= '0; r_sz_d <= '0; r_vld <= '0;
         h <= '0; s <= '0; v <= '0;
      end else if (ce) begin
         r_mx_d[0] <= r2_mx;
         for (int i = 1; i < QW; i++) r_mx_d[i] <= r_mx_d[i-1];
         r_sync[0] <= sync_in;
         for (int i = 1; i < LATENCY; i++) r_sync[i] <= r_sync[i-1];
         r_hz_d <= {r_hz_d[QW-2:0], r2_hzero};
         r_sz_d <= {r_sz_d[QW-2:0], r2_szero};
         r_vld  <= {r_vld[LATENCY-2:0], in_valid};
         h <= r_hz_d[QW-1] ? '0 : w_h_val;
         s <= r_sz_d[QW-1] ? '0 : w_s_val;
         v <= r_mx_d[QW-1];
      end
   end

   assign out_valid = r_vld[LATENCY-1];
   assign sync_out  = r_sync[LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_rgb2hsv_pipe.sv
`default_nettype none
// ============================================================================
// tb_rgb2hsv_pipe : directed and model-checked bench, hue modes 0 and 1 side by side
// Revision        : 1.0
// ============================================================================
module tb_rgb2hsv_pipe;

   localparam int LAT0 = 11;
   localparam int LAT1 = 12;
   localparam int HN   = 2048;

   logic       clk = 1'b0;
   logic       rst_n, ce, in_valid;
   logic [2:0] sync_in;
   logic [7:0] red, green, blue;
   logic       ov0, ov1;
   logic [2:0] so0, so1;
   logic [7:0] h0, s0, v0, s1, v1;
   logic [8:0] h1;

   int checks = 0;
   int errors = 0;

   int         hr [HN];
   int         hg [HN];
   int         hb [HN];
   logic       hv [HN];
   logic [2:0] hs [HN];

   always #5 clk = ~clk;

   rgb2hsv_pipe #(.DATA_W(8), .HUE_MODE(0), .SYNC_W(3)) dut0 (
      .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .sync_in(sync_in),
      .red(red), .green(green), .blue(blue),
      .out_valid(ov0), .sync_out(so0), .h(h0), .s(s0), .v(v0)
   );

   rgb2hsv_pipe #(.DATA_W(8), .HUE_MODE(1), .SYNC_W(3)) dut1 (
      .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .sync_in(sync_in),
      .red(red), .green(green), .blue(blue),
      .out_valid(ov1), .sync_out(so1), .h(h1), .s(s1), .v(v1)
   );

   logic [28:0] act0, act1;
   assign act0 = {ov0, so0, ov0 ? {1'b0, h0, s0, v0} : 25'd0};
   assign act1 = {ov1, so1, ov1 ? {h1, s1, v1} : 25'd0};

   // reference HSV for the history slot k, packed like act0/act1
   function automatic logic [28:0] exp_word(input int mode, input int k);
      int r, g, b, mx, mn, d, hn, hh, ss;
      if (k < 0) return '0;
      if (!hv[k]) return {1'b0, hs[k], 25'd0};
      r = hr[k]; g = hg[k]; b = hb[k];
      mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
      mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
      d = mx - mn;
      if (d == 0) hn = 0;
      else if (mx == r) begin hn = g - b; if (hn < 0) hn += 6 * d; end
      else if (mx == g) hn = b - r + 2 * d;
      else hn = r - g + 4 * d;
      hh = (d == 0) ? 0 : (hn * ((mode == 1) ? 360 : 256)) / (6 * d);
      ss = (mx == 0) ? 0 : (d * 255) / mx;
      return {1'b1, hs[k], 9'(hh), 8'(ss), 8'(mx)};
   endfunction

   task automatic clear_hist();
      for (int i = 0; i < HN; i++) begin
         hr[i] = 0; hg[i] = 0; hb[i] = 0; hv[i] = 1'b0; hs[i] = 3'd0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; ce = 1'b1;
      @(posedge clk);
      #3 rst_n = 1'b1;
   endtask

   task automatic rand_pixel();
      red = 8'($urandom); green = 8'($urandom); blue = 8'($urandom);
      case ($urandom_range(0, 7))
         0: green = red;
         1: blue = red;
         2: begin green = red; blue = red; end
         default: ;
      endcase
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ce = 1'b1; in_valid = 1'b1; sync_in = 3'd7;
      red = 8'd255; green = 8'd10; blue = 8'd20;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({ov0, so0, h0, s0, v0} !== 28'd0) begin
         errors++; $display("FAIL reset_m0 got=%h want=0", {ov0, so0, h0, s0, v0});
      end
      checks++;
      if ({ov1, so1, h1, s1, v1} !== 29'd0) begin
         errors++; $display("FAIL reset_m1 got=%h want=0", {ov1, so1, h1, s1, v1});
      end
      in_valid = 1'b0; sync_in = 3'd0;
      #2 rst_n = 1'b1;
   endtask

   task automatic test_directed();
      int vr [7] = '{255,   0,   0, 128, 0, 255, 200};
      int vg [7] = '{  0, 255,   0, 128, 0,   0, 100};
      int vb [7] = '{  0,   0, 255, 128, 0, 255,  50};
      int e0 [7] = '{  0,  85, 170,   0, 0, 213,  14};
      int e1 [7] = '{  0, 120, 240,   0, 0, 300,  20};
      int es [7] = '{255, 255, 255,   0, 0, 255, 191};
      int ev [7] = '{255, 255, 255, 128, 0, 255, 200};
      for (int k = 0; k < 7; k++) begin
         int lat0, lat1;
         logic [7:0] ch0, cs0, cv0, cs1, cv1;
         logic [8:0] ch1;
         logic [2:0] csy;
         lat0 = -1; lat1 = -1;
         ch0 = '0; cs0 = '0; cv0 = '0; ch1 = '0; cs1 = '0; cv1 = '0; csy = '0;
         @(negedge clk);
         red = 8'(vr[k]); green = 8'(vg[k]); blue = 8'(vb[k]);
         in_valid = 1'b1; sync_in = 3'd5;
         for (int n = 1; n <= 14; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) begin in_valid = 1'b0; sync_in = 3'd0; end
            if (ov0 && lat0 < 0) begin lat0 = n; ch0 = h0; cs0 = s0; cv0 = v0; csy = so0; end
            if (ov1 && lat1 < 0) begin lat1 = n; ch1 = h1; cs1 = s1; cv1 = v1; end
         end
         checks++;
         if (lat0 != LAT0) begin errors++; $display("FAIL lat_m0 vec=%0d got=%0d want=%0d", k, lat0, LAT0); end
         checks++;
         if (lat1 != LAT1) begin errors++; $display("FAIL lat_m1 vec=%0d got=%0d want=%0d", k, lat1, LAT1); end
         checks++;
         if ({ch0, cs0, cv0} !== {8'(e0[k]), 8'(es[k]), 8'(ev[k])}) begin
            errors++;
            $display("FAIL hsv_m0 vec=%0d got h=%0d s=%0d v=%0d want h=%0d s=%0d v=%0d",
                     k, ch0, cs0, cv0, e0[k], es[k], ev[k]);
         end
         checks++;
         if ({ch1, cs1, cv1} !== {9'(e1[k]), 8'(es[k]), 8'(ev[k])}) begin
            errors++;
            $display("FAIL hsv_m1 vec=%0d got h=%0d s=%0d v=%0d want h=%0d s=%0d v=%0d",
                     k, ch1, cs1, cv1, e1[k], es[k], ev[k]);
         end
         checks++;
         if (csy !== 3'd5) begin errors++; $display("FAIL sync_dir vec=%0d got=%0d want=5", k, csy); end
      end
   endtask

   task automatic test_back_to_back();
      int c;
      logic [28:0] x0, x1;
      do_reset();
      clear_hist();
      c = 0;
      for (int t = 0; t < 1000; t++) begin
         @(negedge clk);
         in_valid = 1'($urandom_range(0, 1));
         rand_pixel();
         sync_in = 3'(c);
         hr[c] = red; hg[c] = green; hb[c] = blue; hv[c] = in_valid; hs[c] = sync_in;
         @(posedge clk);
         #1;
         c++;
         x0 = exp_word(0, c - LAT0);
         x1 = exp_word(1, c - LAT1);
         checks++;
         if (act0 !== x0) begin errors++; $display("FAIL b2b_m0 cyc=%0d got=%h want=%h", c, act0, x0); end
         checks++;
         if (act1 !== x1) begin errors++; $display("FAIL b2b_m1 cyc=%0d got=%h want=%h", c, act1, x1); end
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_stall();
      int c;
      logic stall;
      logic [28:0] x0, x1;
      do_reset();
      clear_hist();
      c = 0;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         stall = (t >= 11 && t < 18);
         ce = !stall;
         rand_pixel();
         if (stall) begin
            in_valid = 1'b1; sync_in = 3'($urandom);
         end else begin
            in_valid = (c < 5);
            sync_in = 3'(c);
            hr[c] = red; hg[c] = green; hb[c] = blue; hv[c] = in_valid; hs[c] = sync_in;
         end
         @(posedge clk);
         #1;
         if (!stall) c++;
         x0 = exp_word(0, c - LAT0);
         x1 = exp_word(1, c - LAT1);
         checks++;
         if (act0 !== x0) begin errors++; $display("FAIL stall_m0 t=%0d got=%h want=%h", t, act0, x0); end
         checks++;
         if (act1 !== x1) begin errors++; $display("FAIL stall_m1 t=%0d got=%h want=%h", t, act1, x1); end
      end
      @(negedge clk);
      ce = 1'b1; in_valid = 1'b0;
   endtask

   task automatic test_reset_midstream();
      int c;
      logic [28:0] x0, x1;
      do_reset();
      for (int t = 0; t < 14; t++) begin
         @(negedge clk);
         in_valid = 1'b1; rand_pixel(); sync_in = 3'(t + 1);
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({ov0, so0, h0, s0, v0} !== 28'd0) begin
         errors++; $display("FAIL midrst_m0 got=%h want=0", {ov0, so0, h0, s0, v0});
      end
      checks++;
      if ({ov1, so1, h1, s1, v1} !== 29'd0) begin
         errors++; $display("FAIL midrst_m1 got=%h want=0", {ov1, so1, h1, s1, v1});
      end
      @(posedge clk);
      #3 rst_n = 1'b1;
      clear_hist();
      c = 0;
      for (int t = 0; t < 30; t++) begin
         @(negedge clk);
         in_valid = (c >= 3 && c < 8);
         rand_pixel();
         sync_in = 3'(c);
         hr[c] = red; hg[c] = green; hb[c] = blue; hv[c] = in_valid; hs[c] = sync_in;
         @(posedge clk);
         #1;
         c++;
         x0 = exp_word(0, c - LAT0);
         x1 = exp_word(1, c - LAT1);
         checks++;
         if (act0 !== x0) begin errors++; $display("FAIL postrst_m0 cyc=%0d got=%h want=%h", c, act0, x0); end
         checks++;
         if (act1 !== x1) begin errors++; $display("FAIL postrst_m1 cyc=%0d got=%h want=%h", c, act1, x1); end
      end
   endtask

   initial begin
      rst_n = 1'b0; ce = 1'b1; in_valid = 1'b0; sync_in = 3'd0;
      red = 8'd0; green = 8'd0; blue = 8'd0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_stall();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
